// File: rtl/aud_recorder_multi_if.sv
// Connection bundle for the I2S recorder: codec serial input, record controls
// from the top-level FSM, and the SRAM write port towards the arbiter.
interface aud_recorder_multi_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 20
);
    logic              i_lrc;
    logic              i_data;
    logic              i_start;
    logic              i_pause;
    logic              i_stop;
    logic [1:0]        i_ch_sel;
    logic              i_loop;
    logic [ADDR_W-1:0] o_address;
    logic [DATA_W-1:0] o_data;
    logic              o_we;
    logic [ADDR_W:0]   o_len;
    logic              o_full;
    logic              o_wrapped;
    logic              o_busy;

    modport master (
        input  i_lrc, i_data, i_start, i_pause, i_stop, i_ch_sel, i_loop,
        output o_address, o_data, o_we, o_len, o_full, o_wrapped, o_busy
    );

    modport slave (
        output i_lrc, i_data, i_start, i_pause, i_stop, i_ch_sel, i_loop,
        input  o_address, o_data, o_we, o_len, o_full, o_wrapped, o_busy
    );
endinterface

// File: rtl/aud_recorder_multi.sv
// I2S capture engine: deserialises ADCDAT on BCLK falling edges and writes
// left, right or interleaved stereo samples to SRAM with wrap or stop-at-full.
module aud_recorder_multi #(
    parameter int          DATA_W   = 16,
    parameter int          ADDR_W   = 20,
    parameter int unsigned MAX_ADDR = 2**ADDR_W - 1
) (
    input logic                  i_clk,
    input logic                  i_rst_n,
    aud_recorder_multi_if.master bus
);
    typedef enum logic [2:0] {IDLE, ARM, CAP, PAUSE, DONE} state_t;

    localparam int                CNT_W    = $clog2(DATA_W + 2);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(DATA_W + 1);
    localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(MAX_ADDR);

    state_t            state, state_nx;
    logic              lrc_d;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  bit_pos;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] word;
    logic [ADDR_W-1:0] addr;
    logic              stereo;
    logic              target_ch;
    logic              loop_en;
    logic              exp_ch;
    logic              slot_start;
    logic              capture;

    // Bit position 0 is the I2S delay bit at the edge where word select toggles.
    always_comb begin
        slot_start = (bus.i_lrc != lrc_d);
        bit_pos    = slot_start ? '0 : bit_cnt;
        word       = {shreg[DATA_W-2:0], bus.i_data};
        capture    = 1'b0;
        state_nx   = state;
        case (state)
            IDLE:  if (bus.i_start) state_nx = ARM;
            ARM: begin
                if (bus.i_pause)
                    state_nx = PAUSE;
                else if (slot_start && (bus.i_lrc == target_ch))
                    state_nx = CAP;
            end
            CAP: begin
                if (bus.i_pause) begin
                    state_nx = PAUSE;
                end else if ((bit_pos == CNT_LAST) && (bus.i_lrc == exp_ch)) begin
                    capture = 1'b1;
                    if (!loop_en && (addr == LAST_A))
                        state_nx = DONE;
                    else if (stereo && !exp_ch)
                        state_nx = CAP;
                    else
                        state_nx = ARM;
                end
            end
            PAUSE: if (bus.i_start) state_nx = ARM;
            DONE:  state_nx = DONE;
            default: state_nx = IDLE;
        endcase
        if (bus.i_stop) begin
            state_nx = IDLE;
            capture  = 1'b0;
        end
    end

    always_ff @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Address and length advance on the edge that closes the write strobe.
    always_ff @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lrc_d         <= 1'b0;
            bit_cnt       <= '0;
            shreg         <= '0;
            addr          <= '0;
            stereo        <= 1'b0;
            target_ch     <= 1'b0;
            loop_en       <= 1'b0;
            exp_ch        <= 1'b0;
            bus.o_address <= '0;
            bus.o_data    <= '0;
            bus.o_we      <= 1'b0;
            bus.o_len     <= '0;
            bus.o_full    <= 1'b0;
            bus.o_wrapped <= 1'b0;
        end else begin
            lrc_d   <= bus.i_lrc;
            bit_cnt <= (bit_pos == CNT_SAT) ? CNT_SAT : bit_pos + CNT_W'(1);
            if ((bit_pos != '0) && (bit_pos <= CNT_LAST))
                shreg <= word;

            bus.o_we <= capture;
            if (capture) begin
                bus.o_data    <= word;
                bus.o_address <= addr;
            end

            if (state == IDLE) begin
                addr          <= '0;
                bus.o_len     <= '0;
                bus.o_full    <= 1'b0;
                bus.o_wrapped <= 1'b0;
                stereo        <= (bus.i_ch_sel == 2'd2);
                target_ch     <= (bus.i_ch_sel == 2'd1);
                loop_en       <= bus.i_loop;
            end else if (bus.o_we) begin
                if (!bus.o_len[ADDR_W])
                    bus.o_len <= bus.o_len + (ADDR_W+1)'(1);
                if (addr == LAST_A) begin
                    addr <= '0;
                    if (loop_en) bus.o_wrapped <= 1'b1;
                    else         bus.o_full    <= 1'b1;
                end else begin
                    addr <= addr + ADDR_W'(1);
                end
            end

            // A stereo left capture hands over to the right slot that follows.
            if ((state == ARM) && (state_nx == CAP))
                exp_ch <= target_ch;
            else if (capture && stereo)
                exp_ch <= 1'b1;
        end
    end

    assign bus.o_busy = (state != IDLE) && (state != DONE);

endmodule

// File: tb/tb_aud_recorder_multi.sv
// Directed bench for aud_recorder_multi: 16-bit instance with MAX_ADDR=3 for
// mono/stereo/pause/full/wrap/stop/reset cases, plus a 24-bit instance.
module tb_aud_recorder_multi;
    localparam int DW_A  = 16;
    localparam int DW_B  = 24;
    localparam int AW    = 4;
    localparam int MAX_A = 3;
    localparam int MAX_B = 15;

    localparam logic [2:0] START = 3'b001;
    localparam logic [2:0] PAUSE = 3'b010;
    localparam logic [2:0] STOP  = 3'b100;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b1;

    int compared   = 0;
    int mismatched = 0;
    int base;
    logic ctl_to_b = 1'b0;

    logic [31:0] a_addr[$];
    logic [31:0] a_data[$];
    logic [31:0] a_len[$];
    logic [31:0] b_addr[$];
    logic [31:0] b_data[$];

    always #5 i_clk = ~i_clk;

    aud_recorder_multi_if #(.DATA_W(DW_A), .ADDR_W(AW)) bus_a ();
    aud_recorder_multi_if #(.DATA_W(DW_B), .ADDR_W(AW)) bus_b ();

    aud_recorder_multi #(.DATA_W(DW_A), .ADDR_W(AW), .MAX_ADDR(MAX_A)) dut_a (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus_a)
    );
    aud_recorder_multi #(.DATA_W(DW_B), .ADDR_W(AW), .MAX_ADDR(MAX_B)) dut_b (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus_b)
    );

    // Log every write strobe seen on the rising edge, mid-way through the strobe cycle.
    always @(posedge i_clk) begin
        if (bus_a.o_we) begin
            a_addr.push_back(32'(bus_a.o_address));
            a_data.push_back(32'(bus_a.o_data));
            a_len.push_back(32'(bus_a.o_len));
        end
        if (bus_b.o_we) begin
            b_addr.push_back(32'(bus_b.o_address));
            b_data.push_back(32'(bus_b.o_data));
        end
    end

    function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives nclk bit periods of one word-select level; data bits 1..nbits carry word MSB first.
    task automatic apply_stimulus(input logic lrc, input logic [31:0] word, input int nbits,
                                  input int nclk, input int ctl_at, input logic [2:0] ctl);
        logic       d;
        logic [2:0] c;
        for (int b = 0; b < nclk; b++) begin
            d = (b >= 1 && b <= nbits) ? word[nbits-b] : 1'b0;
            c = (b == ctl_at) ? ctl : 3'b000;
            bus_a.i_lrc  = lrc;
            bus_b.i_lrc  = lrc;
            bus_a.i_data = d;
            bus_b.i_data = d;
            if (ctl_to_b) {bus_b.i_stop, bus_b.i_pause, bus_b.i_start} = c;
            else          {bus_a.i_stop, bus_a.i_pause, bus_a.i_start} = c;
            @(posedge i_clk);
        end
    endtask

    task automatic slot(input logic lrc, input logic [31:0] word);
        apply_stimulus(lrc, word, DW_A, 32, -1, 3'b000);
    endtask

    task automatic slot_ctl(input logic lrc, input logic [31:0] word, input int at,
                            input logic [2:0] ctl);
        apply_stimulus(lrc, word, DW_A, 32, at, ctl);
    endtask

    task automatic pulse(input logic [2:0] ctl);
        apply_stimulus(bus_a.i_lrc, 32'h0, 0, 2, 0, ctl);
    endtask

    initial begin
        {bus_a.i_lrc, bus_a.i_data, bus_a.i_start, bus_a.i_pause, bus_a.i_stop} = '0;
        {bus_b.i_lrc, bus_b.i_data, bus_b.i_start, bus_b.i_pause, bus_b.i_stop} = '0;
        bus_a.i_ch_sel = 2'd0; bus_a.i_loop = 1'b0;
        bus_b.i_ch_sel = 2'd0; bus_b.i_loop = 1'b0;
        #2 i_rst_n = 1'b0;
        repeat (3) @(posedge i_clk);
        check_output("rst_we",      64'(bus_a.o_we),      64'd0);
        check_output("rst_data",    64'(bus_a.o_data),    64'd0);
        check_output("rst_address", 64'(bus_a.o_address), 64'd0);
        check_output("rst_len",     64'(bus_a.o_len),     64'd0);
        check_output("rst_busy",    64'(bus_a.o_busy),    64'd0);
        check_output("rst_full",    64'(bus_a.o_full),    64'd0);
        check_output("rst_wrapped", 64'(bus_a.o_wrapped), 64'd0);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        slot(1'b1, 32'h0);

        $display("[TB] left mono capture");
        base = a_data.size();
        slot(1'b0, 32'h0);
        slot_ctl(1'b1, 32'h0, 5, START);
        slot(1'b0, 32'hA5C3);
        slot(1'b1, 32'h1111);
        check_output("mono_count",   64'(a_data.size() - base), 64'd1);
        check_output("mono_data",    64'(q_at(a_data, base)),   64'hA5C3);
        check_output("mono_addr",    64'(q_at(a_addr, base)),   64'd0);
        check_output("mono_len_we",  64'(q_at(a_len, base)),    64'd0);
        check_output("mono_len",     64'(bus_a.o_len),          64'd1);
        check_output("mono_busy",    64'(bus_a.o_busy),         64'd1);
        pulse(STOP);
        check_output("stop_busy",    64'(bus_a.o_busy),         64'd0);
        check_output("stop_len",     64'(bus_a.o_len),          64'd0);

        $display("[TB] stereo, start mid right slot");
        bus_a.i_ch_sel = 2'd2;
        base = a_data.size();
        slot(1'b0, 32'h5555);
        slot_ctl(1'b1, 32'h6666, 10, START);
        slot(1'b0, 32'h1234);
        slot(1'b1, 32'hBEEF);
        check_output("st_count", 64'(a_data.size() - base),  64'd2);
        check_output("st_addr0", 64'(q_at(a_addr, base)),    64'd0);
        check_output("st_data0", 64'(q_at(a_data, base)),    64'h1234);
        check_output("st_addr1", 64'(q_at(a_addr, base+1)),  64'd1);
        check_output("st_data1", 64'(q_at(a_data, base+1)),  64'hBEEF);
        check_output("st_len",   64'(bus_a.o_len),           64'd2);
        pulse(STOP);

        $display("[TB] pause after 7 data bits");
        bus_a.i_ch_sel = 2'd0;
        base = a_data.size();
        slot_ctl(1'b1, 32'h0, 3, START);
        slot_ctl(1'b0, 32'hFFFF, 8, PAUSE);
        check_output("pause_busy", 64'(bus_a.o_busy), 64'd1);
        slot_ctl(1'b1, 32'h0, 2, START);
        slot(1'b0, 32'h00FF);
        slot(1'b1, 32'h0);
        check_output("pause_count", 64'(a_data.size() - base), 64'd1);
        check_output("pause_data",  64'(q_at(a_data, base)),   64'h00FF);
        check_output("pause_addr",  64'(q_at(a_addr, base)),   64'd0);
        check_output("pause_len",   64'(bus_a.o_len),          64'd1);
        pulse(STOP);

        $display("[TB] stop at full");
        bus_a.i_loop = 1'b0;
        base = a_data.size();
        slot_ctl(1'b1, 32'h0, 2, START);
        for (int k = 1; k <= 4; k++) begin
            slot(1'b0, 32'(k) * 32'h1001);
            slot(1'b1, 32'h0);
        end
        check_output("full_count", 64'(a_data.size() - base),  64'd4);
        check_output("full_addr0", 64'(q_at(a_addr, base)),    64'd0);
        check_output("full_addr3", 64'(q_at(a_addr, base+3)),  64'd3);
        check_output("full_data3", 64'(q_at(a_data, base+3)),  64'h4004);
        check_output("full_flag",  64'(bus_a.o_full),          64'd1);
        check_output("full_busy",  64'(bus_a.o_busy),          64'd0);
        check_output("full_len",   64'(bus_a.o_len),           64'd4);
        pulse(START);
        slot(1'b0, 32'h5005);
        slot(1'b1, 32'h0);
        check_output("done_count", 64'(a_data.size() - base),  64'd4);
        check_output("done_full",  64'(bus_a.o_full),          64'd1);
        pulse(STOP);
        check_output("idle_full",  64'(bus_a.o_full),          64'd0);
        check_output("idle_len",   64'(bus_a.o_len),           64'd0);

        $display("[TB] wrap, right mono");
        bus_a.i_ch_sel = 2'd1;
        bus_a.i_loop   = 1'b1;
        base = a_data.size();
        slot_ctl(1'b0, 32'h0, 2, START);
        for (int k = 1; k <= 5; k++) begin
            slot(1'b1, 32'hC000 + 32'(k));
            slot(1'b0, 32'hDEAD);
        end
        check_output("wrap_count", 64'(a_data.size() - base),  64'd5);
        check_output("wrap_addr3", 64'(q_at(a_addr, base+3)),  64'd3);
        check_output("wrap_addr4", 64'(q_at(a_addr, base+4)),  64'd0);
        check_output("wrap_data4", 64'(q_at(a_data, base+4)),  64'hC005);
        check_output("wrap_flag",  64'(bus_a.o_wrapped),       64'd1);
        check_output("wrap_full",  64'(bus_a.o_full),          64'd0);
        check_output("wrap_len",   64'(bus_a.o_len),           64'd5);
        pulse(STOP);
        check_output("wrap_clear", 64'(bus_a.o_wrapped),       64'd0);

        $display("[TB] stop and pause together in capture");
        bus_a.i_ch_sel = 2'd0;
        bus_a.i_loop   = 1'b0;
        base = a_data.size();
        slot_ctl(1'b1, 32'h0, 2, START);
        slot_ctl(1'b0, 32'h7777, 10, STOP | PAUSE);
        slot(1'b1, 32'h0);
        check_output("sp_busy",  64'(bus_a.o_busy), 64'd0);
        slot(1'b0, 32'h7777);
        slot(1'b1, 32'h0);
        check_output("sp_count", 64'(a_data.size() - base), 64'd0);

        $display("[TB] reset mid slot");
        base = a_data.size();
        slot_ctl(1'b1, 32'h0, 2, START);
        slot(1'b0, 32'h5A5A);
        slot(1'b1, 32'h0);
        check_output("pre_rst_data", 64'(bus_a.o_data), 64'h5A5A);
        apply_stimulus(1'b0, 32'h3C3C, DW_A, 9, -1, 3'b000);
        i_rst_n = 1'b0;
        #1;
        check_output("mrst_data", 64'(bus_a.o_data),    64'd0);
        check_output("mrst_len",  64'(bus_a.o_len),     64'd0);
        check_output("mrst_busy", 64'(bus_a.o_busy),    64'd0);
        check_output("mrst_we",   64'(bus_a.o_we),      64'd0);
        apply_stimulus(1'b0, 32'h0, 0, 23, -1, 3'b000);
        check_output("mrst_count", 64'(a_data.size() - base), 64'd1);
        i_rst_n = 1'b1;
        slot(1'b1, 32'h0);
        check_output("post_rst_busy", 64'(bus_a.o_busy), 64'd0);

        $display("[TB] 24-bit instance");
        ctl_to_b = 1'b1;
        base = b_data.size();
        apply_stimulus(1'b1, 32'h0, DW_B, 32, 2, START);
        apply_stimulus(1'b0, 32'hABCDEF, DW_B, 32, -1, 3'b000);
        apply_stimulus(1'b1, 32'h0, DW_B, 32, -1, 3'b000);
        check_output("w24_count", 64'(b_data.size() - base), 64'd1);
        check_output("w24_data",  64'(q_at(b_data, base)),   64'hABCDEF);
        check_output("w24_addr",  64'(q_at(b_addr, base)),   64'd0);
        check_output("w24_len",   64'(bus_b.o_len),          64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
